// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings, FSM states and defaults for the memory-access / MEM-WB stage.
package mem_wb_stage_pkg;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_WORD = 2'b01;
   localparam logic [1:0] MEM_HALF = 2'b10;
   localparam logic [1:0] MEM_BYTE = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ready bus between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if #(
   parameter int ADDR_W = 32
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/mem_wb_stage_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data, plus sign-extended load extraction.
module mem_lane_align
   import mem_wb_stage_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        write,
   input  logic [1:0]  addr,
   input  logic [31:0] store_data,
   input  logic [31:0] read_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Reads always fetch the full word; only stores narrow the byte enables.
   always_comb begin
      case (addr)
         2'd1:    rd_byte = read_data[15:8];
         2'd2:    rd_byte = read_data[23:16];
         2'd3:    rd_byte = read_data[31:24];
         default: rd_byte = read_data[7:0];
      endcase
      rd_half   = addr[1] ? read_data[31:16] : read_data[15:0];
      be        = 4'b1111;
      wdata     = store_data;
      load_data = read_data;
      case (size)
         MEM_HALF: begin
            if (write) be = addr[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{rd_half[15]}}, rd_half};
         end
         MEM_BYTE: begin
            if (write) be = 4'b0001 << addr;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{rd_byte[7]}}, rd_byte};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with req/ready data-memory access, timeout abandon and the MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned word/half accesses instead of truncating the address.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int ADDR_W  = 32
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  RegWrite,
   input  logic [1:0]            MemWrite,
   input  logic [1:0]            MemRead,
   input  logic [63:0]           ALURes,
   input  logic [31:0]           Data2,
   input  logic [4:0]            DST,
   input  logic [31:0]           PC,
   mem_wb_stage_if.master        mem,
   output logic                  Stall,
   output logic                  RegWriteO,
   output logic [4:0]            DSTO,
   output logic [31:0]           ResultO,
   output logic [31:0]           PCO,
   output logic                  MemErr
);

   localparam int               CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] counter, counter_next;
   logic             is_write, is_load, acc, misalign, issue, drive;
   logic             complete, err_next;
   logic [1:0]       size;
   logic [3:0]       lane_be;
   logic [31:0]      lane_wdata, load_data;
   logic             unused_alu_hi;

   assign is_write      = MemWrite != MEM_NONE;
   assign is_load       = !is_write && (MemRead != MEM_NONE);
   assign acc           = is_write || is_load;
   assign size          = is_write ? MemWrite : MemRead;
   assign unused_alu_hi = ^ALURes[63:32];

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((size == MEM_WORD) && (ALURes[1:0] != 2'b00)) ||
                     ((size == MEM_HALF) && ALURes[0]);
`else
   assign misalign = 1'b0;
`endif

   assign issue = acc && !misalign;

   // Request lines are gated by Rst so an in-flight access vanishes the instant reset hits.
   assign drive         = !Rst && (((state == ST_IDLE) && issue) || (state == ST_WAIT));
   assign mem.mem_req   = drive;
   assign mem.mem_we    = drive && is_write;
   assign mem.mem_addr  = drive ? {ALURes[ADDR_W-1:2], 2'b00} : '0;
   assign mem.mem_be    = drive ? lane_be : 4'b0000;
   assign mem.mem_wdata = (drive && is_write) ? lane_wdata : 32'h0;

   assign Stall = !Rst && !mem.mem_ready &&
                  (((state == ST_IDLE) && issue) || ((state == ST_WAIT) && (counter < LAST)));

   mem_lane_align u_lane (
      .size       (size),
      .write      (is_write),
      .addr       (ALURes[1:0]),
      .store_data (Data2),
      .read_data  (mem.mem_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= ST_IDLE;
         counter <= '0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
      end
   end

   // Anything that does not complete this cycle (wait, timeout, trap) becomes a bubble.
   always_comb begin
      state_next   = state;
      counter_next = counter;
      complete     = 1'b0;
      err_next     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!acc) begin
               complete = 1'b1;
            end else if (misalign) begin
               err_next = 1'b1;
            end else if (mem.mem_ready) begin
               complete = 1'b1;
            end else begin
               state_next   = ST_WAIT;
               counter_next = '0;
            end
         end
         ST_WAIT: begin
            if (mem.mem_ready) begin
               complete   = 1'b1;
               state_next = ST_IDLE;
            end else if (counter == LAST) begin
               err_next   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               counter_next = counter + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         RegWriteO <= 1'b0;
         DSTO      <= '0;
         ResultO   <= '0;
         PCO       <= '0;
         MemErr    <= 1'b0;
      end else begin
         MemErr <= err_next;
         if (complete) begin
            RegWriteO <= RegWrite;
            DSTO      <= DST;
            ResultO   <= is_load ? load_data : ALURes[31:0];
            PCO       <= PC;
         end else begin
            RegWriteO <= 1'b0;
            DSTO      <= '0;
            ResultO   <= '0;
            PCO       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed corner cases, then randomised traffic
// checked every cycle against a per-instruction behavioural model.
`timescale 1ns/1ps
module tb_mem_wb_stage;

   localparam int TIMEOUT = 4;
   localparam int ADDR_W  = 32;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        RegWrite;
   logic [1:0]  MemWrite, MemRead;
   logic [63:0] ALURes;
   logic [31:0] Data2, PC;
   logic [4:0]  DST;
   logic        Stall, RegWriteO, MemErr;
   logic [4:0]  DSTO;
   logic [31:0] ResultO, PCO;

   mem_wb_stage_if #(.ADDR_W(ADDR_W)) memBus ();

   mem_wb_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ALURes    (ALURes),
      .Data2     (Data2),
      .DST       (DST),
      .PC        (PC),
      .mem       (memBus),
      .Stall     (Stall),
      .RegWriteO (RegWriteO),
      .DSTO      (DSTO),
      .ResultO   (ResultO),
      .PCO       (PCO),
      .MemErr    (MemErr)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic        rw;
      logic [4:0]  dst;
      logic [31:0] res;
      logic [31:0] pc;
      logic        err;
   } wb_t;

   wb_t         expReg, expRegNext;
   logic        expReq, expWe, expStall;
   logic [31:0] expAddr, expWdata;
   logic [3:0]  expBe;

   logic        curRw;
   logic [1:0]  curMw, curMr;
   logic [63:0] curAlu;
   logic [31:0] curD2, curPc, curRd;
   logic [4:0]  curDst;
   int          curLat;
   bit          curRdRand;
   int          k;
   bit          held;

   int assertCount = 0;
   int failCount   = 0;
   bit checkOn     = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: every cycle, mid-period, against the model.
   always @(negedge Clk) begin
      if (checkOn) begin
         checkOutput("mem_req",   memBus.mem_req,   expReq);
         checkOutput("mem_we",    memBus.mem_we,    expWe);
         checkOutput("mem_addr",  memBus.mem_addr,  expAddr);
         checkOutput("mem_be",    memBus.mem_be,    expBe);
         checkOutput("mem_wdata", memBus.mem_wdata, expWdata);
         checkOutput("Stall",     Stall,            expStall);
         checkOutput("RegWriteO", RegWriteO,        expReg.rw);
         checkOutput("DSTO",      DSTO,             expReg.dst);
         checkOutput("ResultO",   ResultO,          expReg.res);
         checkOutput("PCO",       PCO,              expReg.pc);
         checkOutput("MemErr",    MemErr,           expReg.err);
      end
   end

   task automatic loadInstr(input logic rw, input logic [1:0] mw, input logic [1:0] mr,
                            input logic [63:0] alu, input logic [31:0] d2, input logic [4:0] dst,
                            input logic [31:0] pc, input int lat, input logic [31:0] rd);
      curRw = rw; curMw = mw; curMr = mr; curAlu = alu; curD2 = d2; curDst = dst;
      curPc = pc; curLat = lat; curRd = rd; curRdRand = 0; k = 0; held = 0;
   endtask

   task automatic randomInstr();
      curRw     = 1'($urandom_range(0, 1));
      curMw     = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      curMr     = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      curAlu    = {$urandom, $urandom};
      curD2     = $urandom;
      curDst    = 5'($urandom);
      curPc     = $urandom;
      curLat    = $urandom_range(0, TIMEOUT + 1);
      curRdRand = 1;
      k         = 0;
      held      = 0;
   endtask

   // Model: the k-th cycle of an instruction; memory answers on cycle curLat, and an
   // access that has stalled TIMEOUT cycles without an answer is abandoned with an error.
   task automatic driveAndModel();
      logic        isW, isL, acc, mis, req, rdy;
      logic [1:0]  size, a;
      logic [31:0] rd, ld, tmp;
      isW  = curMw != 2'b00;
      isL  = !isW && (curMr != 2'b00);
      acc  = isW || isL;
      size = isW ? curMw : curMr;
      a    = curAlu[1:0];
      mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis  = ((size == 2'b01) && (a != 2'b00)) || ((size == 2'b10) && a[0]);
`endif
      req  = acc && !mis;
      rdy  = req && (k == curLat);
      rd   = curRdRand ? $urandom : curRd;

      RegWrite = curRw; MemWrite = curMw; MemRead = curMr; ALURes = curAlu;
      Data2 = curD2; DST = curDst; PC = curPc;
      memBus.mem_ready = rdy;
      memBus.mem_rdata = rd;

      expReq   = req;
      expWe    = req && isW;
      expAddr  = req ? {curAlu[31:2], 2'b00} : 32'h0;
      expBe    = 4'h0;
      expWdata = 32'h0;
      if (req) begin
         if (!isW || size == 2'b01) expBe = 4'hF;
         else if (size == 2'b10)    expBe = a[1] ? 4'hC : 4'h3;
         else                       expBe = 4'h1 << a;
         if (isW) begin
            if (size == 2'b01)      expWdata = curD2;
            else if (size == 2'b10) expWdata = {2{curD2[15:0]}};
            else                    expWdata = {4{curD2[7:0]}};
         end
      end

      if (size == 2'b01) begin
         ld = rd;
      end else if (size == 2'b10) begin
         tmp = rd >> (16 * a[1]);
         ld  = {{16{tmp[15]}}, tmp[15:0]};
      end else begin
         tmp = rd >> (8 * a);
         ld  = {{24{tmp[7]}}, tmp[7:0]};
      end

      expStall   = req && !rdy && (k < TIMEOUT);
      expRegNext = '0;
      if (!expStall) begin
         if (!acc || rdy) begin
            expRegNext.rw  = curRw;
            expRegNext.dst = curDst;
            expRegNext.res = isL ? ld : curAlu[31:0];
            expRegNext.pc  = curPc;
         end else begin
            expRegNext.err = 1'b1;
         end
      end
      held = expStall;
      k++;
   endtask

   task automatic applyStimulus();
      @(posedge Clk);
      #1;
      expReg = expRegNext;
      driveAndModel();
   endtask

   task automatic releaseReset();
      @(posedge Clk);
      #1;
      Rst    = 1'b0;
      expReg = '0;
      loadInstr(1'b0, 2'b00, 2'b00, 64'h0, 32'h0, 5'd0, 32'h0, 0, 32'h0);
      driveAndModel();
   endtask

   task automatic assertResetNow();
      expReq = 0; expWe = 0; expAddr = 0; expBe = 0; expWdata = 0; expStall = 0;
      expReg = '0; expRegNext = '0; held = 0;
      Rst = 1'b1;
      #1;
      checkOutput("rst-mid mem_req",  memBus.mem_req,  64'd0);
      checkOutput("rst-mid Stall",    Stall,           64'd0);
      checkOutput("rst-mid mem_addr", memBus.mem_addr, 64'd0);
      checkOutput("rst-mid MemErr",   MemErr,          64'd0);
   endtask

   initial begin
      Rst = 1'b1; RegWrite = 0; MemWrite = 0; MemRead = 0; ALURes = 0; Data2 = 0; DST = 0; PC = 0;
      memBus.mem_ready = 0; memBus.mem_rdata = 0;
      expReg = '0; expRegNext = '0; expReq = 0; expWe = 0; expAddr = 0; expBe = 0;
      expWdata = 0; expStall = 0; held = 0; k = 0;

      repeat (2) @(posedge Clk);
      #1;
      checkOn = 1;
      checkOutput("reset RegWriteO", RegWriteO,        64'd0);
      checkOutput("reset DSTO",      DSTO,             64'd0);
      checkOutput("reset ResultO",   ResultO,          64'd0);
      checkOutput("reset PCO",       PCO,              64'd0);
      checkOutput("reset MemErr",    MemErr,           64'd0);
      checkOutput("reset mem_req",   memBus.mem_req,   64'd0);
      checkOutput("reset mem_we",    memBus.mem_we,    64'd0);
      checkOutput("reset mem_be",    memBus.mem_be,    64'd0);
      checkOutput("reset mem_addr",  memBus.mem_addr,  64'd0);
      checkOutput("reset mem_wdata", memBus.mem_wdata, 64'd0);
      releaseReset();

      // ALU op with no memory access
      loadInstr(1'b1, 2'b00, 2'b00, 64'h1234, 32'h0, 5'd7, 32'h100, 0, 32'h0);
      applyStimulus(); #1;
      checkOutput("alu Stall",   Stall,          64'd0);
      checkOutput("alu mem_req", memBus.mem_req, 64'd0);

      // lb at 0x102, two wait cycles
      loadInstr(1'b1, 2'b00, 2'b11, 64'h102, 32'h0, 5'd3, 32'h104, 2, 32'h0080_0000);
      applyStimulus(); #1;
      checkOutput("alu RegWriteO", RegWriteO,       64'd1);
      checkOutput("alu DSTO",      DSTO,            64'd7);
      checkOutput("alu ResultO",   ResultO,         64'h1234);
      checkOutput("lb Stall w0",   Stall,           64'd1);
      checkOutput("lb mem_be",     memBus.mem_be,   64'hF);
      checkOutput("lb mem_addr",   memBus.mem_addr, 64'h100);
      applyStimulus(); #1;
      checkOutput("lb Stall w1",   Stall,           64'd1);
      applyStimulus(); #1;
      checkOutput("lb Stall done", Stall,           64'd0);

      // sh at 0x206, zero-wait
      loadInstr(1'b0, 2'b10, 2'b00, 64'h206, 32'hABCD_1234, 5'd0, 32'h108, 0, 32'h0);
      applyStimulus(); #1;
      checkOutput("lb ResultO",   ResultO,          64'hFFFF_FF80);
      checkOutput("lb DSTO",      DSTO,             64'd3);
      checkOutput("sh mem_be",    memBus.mem_be,    64'hC);
      checkOutput("sh mem_wdata", memBus.mem_wdata, 64'h1234_1234);
      checkOutput("sh mem_we",    memBus.mem_we,    64'd1);
      checkOutput("sh Stall",     Stall,            64'd0);

      // lw that never gets ready
      loadInstr(1'b1, 2'b00, 2'b01, 64'h400, 32'h0, 5'd9, 32'h10C, 99, 32'hDEAD_BEEF);
      for (int i = 0; i < TIMEOUT; i++) begin
         applyStimulus(); #1;
         checkOutput("timeout Stall", Stall, 64'd1);
      end
      applyStimulus(); #1;
      checkOutput("timeout Stall drop", Stall,  64'd0);
      checkOutput("timeout early err",  MemErr, 64'd0);
      loadInstr(1'b1, 2'b00, 2'b00, 64'h55, 32'h0, 5'd2, 32'h110, 0, 32'h0);
      applyStimulus(); #1;
      checkOutput("timeout MemErr",    MemErr,    64'd1);
      checkOutput("timeout RegWriteO", RegWriteO, 64'd0);

      // sw at 0x301
      loadInstr(1'b0, 2'b01, 2'b00, 64'h301, 32'hCAFE_F00D, 5'd0, 32'h114, 0, 32'h0);
      applyStimulus(); #1;
      checkOutput("MemErr not sticky", MemErr,    64'd0);
      checkOutput("nop RegWriteO",     RegWriteO, 64'd1);
      checkOutput("nop DSTO",          DSTO,      64'd2);
`ifdef MISALIGN_TRAP_EN
      checkOutput("sw mis mem_req", memBus.mem_req, 64'd0);
      checkOutput("sw mis Stall",   Stall,          64'd0);
`else
      checkOutput("sw mem_addr", memBus.mem_addr, 64'h300);
      checkOutput("sw mem_be",   memBus.mem_be,   64'hF);
`endif
      loadInstr(1'b0, 2'b00, 2'b00, 64'h0, 32'h0, 5'd0, 32'h118, 0, 32'h0);
      applyStimulus(); #1;
`ifdef MISALIGN_TRAP_EN
      checkOutput("sw mis MemErr", MemErr, 64'd1);
`else
      checkOutput("sw MemErr", MemErr, 64'd0);
      checkOutput("sw PCO",    PCO,    64'h114);
`endif

      // Reset while a lw is waiting
      loadInstr(1'b1, 2'b00, 2'b01, 64'h500, 32'h0, 5'd4, 32'h11C, 99, 32'h0);
      applyStimulus();
      applyStimulus(); #1;
      checkOutput("pre-rst Stall", Stall, 64'd1);
      assertResetNow();
      releaseReset(); #1;
      checkOutput("post-rst Stall",   Stall,          64'd0);
      checkOutput("post-rst mem_req", memBus.mem_req, 64'd0);

      // Zero-wait lw straight after reset
      loadInstr(1'b1, 2'b00, 2'b01, 64'h20, 32'h0, 5'd5, 32'h120, 0, 32'h8765_4321);
      applyStimulus(); #1;
      checkOutput("lw0 mem_req", memBus.mem_req, 64'd1);
      checkOutput("lw0 Stall",   Stall,          64'd0);
      loadInstr(1'b0, 2'b00, 2'b00, 64'h0, 32'h0, 5'd0, 32'h124, 0, 32'h0);
      applyStimulus(); #1;
      checkOutput("lw0 ResultO", ResultO, 64'h8765_4321);

      // Randomised traffic
      for (int c = 0; c < 2500; c++) begin
         if (!held) randomInstr();
         applyStimulus();
      end
      for (int c = 0; c < TIMEOUT + 2 && held; c++) applyStimulus();
      loadInstr(1'b0, 2'b00, 2'b00, 64'h0, 32'h0, 5'd0, 32'h0, 0, 32'h0);
      applyStimulus();
      @(negedge Clk);
      #1;
      checkOn = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
